// File: rtl/exc_commit.sv
`default_nettype none
// ============================================================================
//  Module   : exc_commit
//  Purpose  : Writeback-stage exception / interrupt commit unit. Resolves the
//             MEM-stage exception flags and pending interrupts of each
//             accepted instruction into one prioritised excode, pulses
//             cp0_ex / eret_flush for one cycle, then drops wrong-path
//             instructions until fetch acknowledges the redirect.
//  Options  : define EXC_INT_EN to enable interrupt detection; when it is
//             undefined no interrupt is ever taken (excode 0x00 never issued).
//  Revision : 1.0 - initial release
// ============================================================================
module exc_commit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic        in_bd,
    input  logic        in_ex_if_adel,
    input  logic        in_ex_ri,
    input  logic        in_ex_ov,
    input  logic        in_ex_sys,
    input  logic        in_ex_bp,
    input  logic        in_ex_ld_adel,
    input  logic        in_ex_st_ades,
    input  logic [31:0] in_daddr,
    input  logic        in_eret,
    input  logic        in_mtc0,
    input  logic [4:0]  in_cp0_addr,
    input  logic [31:0] in_cp0_wdata,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic [7:0]  status_im,
    input  logic [7:0]  cause_ip,
    input  logic        redirect_ack,
    output logic        cp0_ex,
    output logic [4:0]  cp0_excode,
    output logic        cp0_bd,
    output logic [31:0] cp0_pc,
    output logic [31:0] cp0_badvaddr,
    output logic        eret_flush,
    output logic        cp0_we,
    output logic [4:0]  cp0_addr,
    output logic [31:0] cp0_wdata,
    output logic        wb_commit
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_EXC   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        cp0_ex_q, cp0_ex_d;
    logic        eret_flush_q, eret_flush_d;
    logic        cp0_we_q, cp0_we_d;
    logic        wb_commit_q, wb_commit_d;
    logic [4:0]  cp0_excode_q, cp0_excode_d;
    logic        cp0_bd_q, cp0_bd_d;
    logic [31:0] cp0_pc_q, cp0_pc_d;
    logic [31:0] cp0_badvaddr_q, cp0_badvaddr_d;
    logic [4:0]  cp0_addr_q, cp0_addr_d;
    logic [31:0] cp0_wdata_q, cp0_wdata_d;

    logic        int_pend;
    logic        exc_any;
    logic [4:0]  exc_code;
    logic [31:0] exc_bad;
    logic        accept;

`ifdef EXC_INT_EN
    assign int_pend = status_ie & ~status_exl & |(status_im & cause_ip);
`else
    // CP0 status/cause are not needed without interrupt support
    logic unused_cp0_state;
    assign unused_cp0_state = ^{status_ie, status_exl, status_im, cause_ip};
    assign int_pend = 1'b0;
`endif

    assign accept = in_valid & in_ready_q;

    // Prioritised exception decode; badvaddr only carries an address for AdEL/AdES
    always_comb begin
        exc_any  = 1'b1;
        exc_code = 5'h00;
        exc_bad  = 32'h0;
        if (int_pend) begin
            exc_code = 5'h00;
        end else if (in_ex_if_adel) begin
            exc_code = 5'h04;
            exc_bad  = in_pc;
        end else if (in_ex_ri) begin
            exc_code = 5'h0a;
        end else if (in_ex_ov) begin
            exc_code = 5'h0c;
        end else if (in_ex_sys) begin
            exc_code = 5'h08;
        end else if (in_ex_bp) begin
            exc_code = 5'h09;
        end else if (in_ex_ld_adel) begin
            exc_code = 5'h04;
            exc_bad  = in_daddr;
        end else if (in_ex_st_ades) begin
            exc_code = 5'h05;
            exc_bad  = in_daddr;
        end else begin
            exc_any  = 1'b0;
        end
    end

    // Next-state and next-output logic; pulses default low, CP0 payload holds
    always_comb begin
        state_d        = state_q;
        cp0_ex_d       = 1'b0;
        eret_flush_d   = 1'b0;
        cp0_we_d       = 1'b0;
        wb_commit_d    = 1'b0;
        cp0_excode_d   = cp0_excode_q;
        cp0_bd_d       = cp0_bd_q;
        cp0_pc_d       = cp0_pc_q;
        cp0_badvaddr_d = cp0_badvaddr_q;
        cp0_addr_d     = cp0_addr_q;
        cp0_wdata_d    = cp0_wdata_q;
        case (state_q)
            S_RUN: begin
                if (accept) begin
                    if (exc_any) begin
                        // exception beats eret and mtc0 on the same instruction
                        cp0_ex_d       = 1'b1;
                        cp0_excode_d   = exc_code;
                        cp0_bd_d       = in_bd;
                        cp0_pc_d       = in_pc;
                        cp0_badvaddr_d = exc_bad;
                        state_d        = S_EXC;
                    end else if (in_eret) begin
                        eret_flush_d   = 1'b1;
                        state_d        = S_EXC;
                    end else begin
                        wb_commit_d    = 1'b1;
                        if (in_mtc0) begin
                            cp0_we_d    = 1'b1;
                            cp0_addr_d  = in_cp0_addr;
                            cp0_wdata_d = in_cp0_wdata;
                        end
                    end
                end
            end
            S_EXC: begin
                // the pulse is visible this cycle; start discarding next
                state_d = S_FLUSH;
            end
            S_FLUSH: begin
                // anything accepted here is wrong-path, including the ack cycle
                if (redirect_ack) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
        in_ready_d = (state_d != S_EXC);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= S_RUN;
            in_ready_q     <= 1'b1;
            cp0_ex_q       <= 1'b0;
            eret_flush_q   <= 1'b0;
            cp0_we_q       <= 1'b0;
            wb_commit_q    <= 1'b0;
            cp0_excode_q   <= 5'h00;
            cp0_bd_q       <= 1'b0;
            cp0_pc_q       <= 32'h0;
            cp0_badvaddr_q <= 32'h0;
            cp0_addr_q     <= 5'h00;
            cp0_wdata_q    <= 32'h0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            cp0_ex_q       <= cp0_ex_d;
            eret_flush_q   <= eret_flush_d;
            cp0_we_q       <= cp0_we_d;
            wb_commit_q    <= wb_commit_d;
            cp0_excode_q   <= cp0_excode_d;
            cp0_bd_q       <= cp0_bd_d;
            cp0_pc_q       <= cp0_pc_d;
            cp0_badvaddr_q <= cp0_badvaddr_d;
            cp0_addr_q     <= cp0_addr_d;
            cp0_wdata_q    <= cp0_wdata_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign cp0_ex       = cp0_ex_q;
    assign eret_flush   = eret_flush_q;
    assign cp0_we       = cp0_we_q;
    assign wb_commit    = wb_commit_q;
    assign cp0_excode   = cp0_excode_q;
    assign cp0_bd       = cp0_bd_q;
    assign cp0_pc       = cp0_pc_q;
    assign cp0_badvaddr = cp0_badvaddr_q;
    assign cp0_addr     = cp0_addr_q;
    assign cp0_wdata    = cp0_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_exc_commit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exc_commit
//  Purpose  : Self-checking bench for exc_commit: directed scenarios followed
//             by randomized traffic against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_exc_commit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        in_bd;
    logic        in_ex_if_adel, in_ex_ri, in_ex_ov, in_ex_sys, in_ex_bp;
    logic        in_ex_ld_adel, in_ex_st_ades;
    logic [31:0] in_daddr;
    logic        in_eret, in_mtc0;
    logic [4:0]  in_cp0_addr;
    logic [31:0] in_cp0_wdata;
    logic        status_ie, status_exl;
    logic [7:0]  status_im, cause_ip;
    logic        redirect_ack;
    logic        cp0_ex, cp0_bd, eret_flush, cp0_we, wb_commit;
    logic [4:0]  cp0_excode, cp0_addr;
    logic [31:0] cp0_pc, cp0_badvaddr, cp0_wdata;

    always #5 clk = ~clk;

    exc_commit dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_bd        (in_bd),
        .in_ex_if_adel(in_ex_if_adel),
        .in_ex_ri     (in_ex_ri),
        .in_ex_ov     (in_ex_ov),
        .in_ex_sys    (in_ex_sys),
        .in_ex_bp     (in_ex_bp),
        .in_ex_ld_adel(in_ex_ld_adel),
        .in_ex_st_ades(in_ex_st_ades),
        .in_daddr     (in_daddr),
        .in_eret      (in_eret),
        .in_mtc0      (in_mtc0),
        .in_cp0_addr  (in_cp0_addr),
        .in_cp0_wdata (in_cp0_wdata),
        .status_ie    (status_ie),
        .status_exl   (status_exl),
        .status_im    (status_im),
        .cause_ip     (cause_ip),
        .redirect_ack (redirect_ack),
        .cp0_ex       (cp0_ex),
        .cp0_excode   (cp0_excode),
        .cp0_bd       (cp0_bd),
        .cp0_pc       (cp0_pc),
        .cp0_badvaddr (cp0_badvaddr),
        .eret_flush   (eret_flush),
        .cp0_we       (cp0_we),
        .cp0_addr     (cp0_addr),
        .cp0_wdata    (cp0_wdata),
        .wb_commit    (wb_commit)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: pipeline phase (0 = committing, 1 = pulse cycle,
    // 2 = discarding until redirect ack) and the expected outputs.
    int          phase = 0;
    bit          e_ready, e_ex, e_eret, e_we, e_commit, e_bd;
    logic [4:0]  e_code, e_addr;
    logic [31:0] e_pc, e_bad, e_wdata;

    // Walk the priority table; returns whether any cause hit
    task automatic ref_cause(output bit hit, output logic [4:0] code, output logic [31:0] bad);
        bit       flags [8];
        int       codes [8] = '{0, 4, 10, 12, 8, 9, 4, 5};
        bit       ipend;
`ifdef EXC_INT_EN
        ipend = status_ie && !status_exl && ((status_im & cause_ip) != 8'h0);
`else
        ipend = 1'b0;
`endif
        flags = '{ipend, in_ex_if_adel, in_ex_ri, in_ex_ov, in_ex_sys, in_ex_bp,
                  in_ex_ld_adel, in_ex_st_ades};
        hit  = 1'b0;
        code = 5'h0;
        bad  = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (!hit && flags[i]) begin
                hit  = 1'b1;
                code = 5'(codes[i]);
                if (i == 1)      bad = in_pc;
                else if (i >= 6) bad = in_daddr;
            end
        end
    endtask

    // Predict from the inputs presented now, clock once, compare
    task automatic step();
        bit          hit;
        logic [4:0]  code;
        logic [31:0] bad;
        e_ex = 0; e_eret = 0; e_we = 0; e_commit = 0;
        if (!resetn) begin
            phase = 0;
        end else if (phase == 1) begin
            phase = 2;
        end else if (phase == 2) begin
            if (redirect_ack) phase = 0;
        end else if (in_valid) begin
            ref_cause(hit, code, bad);
            if (hit) begin
                e_ex = 1; e_code = code; e_bad = bad; e_pc = in_pc; e_bd = in_bd;
                phase = 1;
            end else if (in_eret) begin
                e_eret = 1;
                phase  = 1;
            end else begin
                e_commit = 1;
                if (in_mtc0) begin
                    e_we = 1; e_addr = in_cp0_addr; e_wdata = in_cp0_wdata;
                end
            end
        end
        e_ready = (phase != 1);
        @(posedge clk);
        #1;
        check("in_ready", 32'(in_ready), 32'(e_ready));
        check("cp0_ex", 32'(cp0_ex), 32'(e_ex));
        check("eret_flush", 32'(eret_flush), 32'(e_eret));
        check("cp0_we", 32'(cp0_we), 32'(e_we));
        check("wb_commit", 32'(wb_commit), 32'(e_commit));
        if (e_ex) begin
            check("cp0_excode", 32'(cp0_excode), 32'(e_code));
            check("cp0_pc", cp0_pc, e_pc);
            check("cp0_bd", 32'(cp0_bd), 32'(e_bd));
            check("cp0_badvaddr", cp0_badvaddr, e_bad);
        end
        if (e_we) begin
            check("cp0_addr", 32'(cp0_addr), 32'(e_addr));
            check("cp0_wdata", cp0_wdata, e_wdata);
        end
    endtask

    task automatic idle();
        resetn = 1; in_valid = 0; in_pc = 0; in_bd = 0;
        in_ex_if_adel = 0; in_ex_ri = 0; in_ex_ov = 0; in_ex_sys = 0; in_ex_bp = 0;
        in_ex_ld_adel = 0; in_ex_st_ades = 0; in_daddr = 0;
        in_eret = 0; in_mtc0 = 0; in_cp0_addr = 0; in_cp0_wdata = 0;
        status_ie = 0; status_exl = 0; status_im = 0; cause_ip = 0;
        redirect_ack = 0;
    endtask

    // Leave the pulse cycle, then acknowledge the redirect
    task automatic recover();
        idle(); step();
        redirect_ack = 1; step();
        idle();
    endtask

    initial begin
        idle();
        resetn = 0;
        step();
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst cp0_ex", 32'(cp0_ex), 32'd0);
        check("rst wb_commit", 32'(wb_commit), 32'd0);
        check("rst cp0_we", 32'(cp0_we), 32'd0);
        check("rst eret_flush", 32'(eret_flush), 32'd0);
        check("rst cp0_excode", 32'(cp0_excode), 32'd0);
        check("rst cp0_pc", cp0_pc, 32'd0);
        check("rst cp0_badvaddr", cp0_badvaddr, 32'd0);

        // mtc0 commit
        idle();
        in_valid = 1; in_pc = 32'hBFC00010; in_mtc0 = 1;
        in_cp0_addr = 5'h0B; in_cp0_wdata = 32'h1234;
        step();
        check("mtc0 we", 32'(cp0_we), 32'd1);
        check("mtc0 addr", 32'(cp0_addr), 32'h0B);
        check("mtc0 wdata", cp0_wdata, 32'h1234);
        check("mtc0 commit", 32'(wb_commit), 32'd1);
        check("mtc0 ex", 32'(cp0_ex), 32'd0);

        // overflow outranks store address error
        idle();
        in_valid = 1; in_pc = 32'h100; in_ex_ov = 1; in_ex_st_ades = 1; in_daddr = 32'h1003;
        step();
        check("ov ex", 32'(cp0_ex), 32'd1);
        check("ov excode", 32'(cp0_excode), 32'h0c);
        check("ov badvaddr", cp0_badvaddr, 32'd0);
        check("ov in_ready", 32'(in_ready), 32'd0);
        idle(); step();
        check("ov pulse len", 32'(cp0_ex), 32'd0);
        redirect_ack = 1; step(); idle();

        // store address error in a delay slot
        in_valid = 1; in_pc = 32'h80; in_bd = 1; in_ex_st_ades = 1; in_daddr = 32'h1003;
        step();
        check("ades excode", 32'(cp0_excode), 32'h05);
        check("ades badvaddr", cp0_badvaddr, 32'h1003);
        check("ades bd", 32'(cp0_bd), 32'd1);
        check("ades pc", cp0_pc, 32'h80);
        recover();

        // interrupt vs syscall
        in_valid = 1; in_pc = 32'h200; in_ex_sys = 1;
        status_ie = 1; status_exl = 0; status_im = 8'h80; cause_ip = 8'h80;
        step();
`ifdef EXC_INT_EN
        check("int excode", 32'(cp0_excode), 32'h00);
`else
        check("int excode", 32'(cp0_excode), 32'h08);
`endif
        recover();

        // eret then three dropped instructions, ack on the third
        in_valid = 1; in_pc = 32'h300; in_eret = 1;
        step();
        check("eret pulse", 32'(eret_flush), 32'd1);
        idle(); step();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1; in_pc = 32'h400 + 32'(k * 4); in_mtc0 = 1;
            redirect_ack = (k == 2);
            step();
            check("drop commit", 32'(wb_commit), 32'd0);
            check("drop we", 32'(cp0_we), 32'd0);
        end
        idle();
        in_valid = 1; in_pc = 32'h500;
        step();
        check("post-flush commit", 32'(wb_commit), 32'd1);

        // reset while discarding
        idle();
        in_valid = 1; in_ex_ri = 1;
        step();
        idle(); step();
        resetn = 0; step();
        check("flush rst ready", 32'(in_ready), 32'd1);
        idle();
        in_valid = 1; in_pc = 32'h600;
        step();
        check("flush rst commit", 32'(wb_commit), 32'd1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            resetn        = ($urandom_range(0, 63) != 0);
            in_valid      = ($urandom_range(0, 3) != 0);
            in_pc         = $urandom;
            in_bd         = 1'($urandom_range(0, 1));
            in_ex_if_adel = ($urandom_range(0, 15) == 0);
            in_ex_ri      = ($urandom_range(0, 15) == 0);
            in_ex_ov      = ($urandom_range(0, 15) == 0);
            in_ex_sys     = ($urandom_range(0, 15) == 0);
            in_ex_bp      = ($urandom_range(0, 15) == 0);
            in_ex_ld_adel = ($urandom_range(0, 15) == 0);
            in_ex_st_ades = ($urandom_range(0, 15) == 0);
            in_daddr      = $urandom;
            in_eret       = ($urandom_range(0, 9) == 0);
            in_mtc0       = ($urandom_range(0, 3) == 0);
            in_cp0_addr   = 5'($urandom);
            in_cp0_wdata  = $urandom;
            status_ie     = 1'($urandom_range(0, 1));
            status_exl    = ($urandom_range(0, 3) == 0);
            status_im     = 8'($urandom);
            cause_ip      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            redirect_ack  = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
